// File: rtl/sp1_ff_pipe_if.sv
// sp1_ff_pipe_if: valid/ready handshake bundle for both ends of the elastic pipe
interface sp1_ff_pipe_if #(parameter int DW = 32);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/sp1_ff_pipe.sv
// sp1_ff_pipe: DEPTH-stage elastic register chain with bubble compaction and flush
module sp1_ff_pipe #(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  sp1_ff_pipe_if.slave  bus,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0] v_q, v_d, go;
  logic [DW-1:0]    d_q [DEPTH];
  logic [DW-1:0]    d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             full_above;
  // go[i] is the ready chain unrolled: a stage may load unless it and every later stage is full and the sink stalls
  always_comb begin
    full_above = 1'b1;
    go = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      full_above = full_above & v_q[i];
      go[i] = bus.out_ready | !full_above;
    end
  end
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    for (int i = 1; i < DEPTH; i++) begin
      if (go[i]) begin
        v_d[i] = v_q[i-1];
        d_d[i] = v_q[i-1] ? d_q[i-1] : d_q[i];
      end
    end
    if (go[0]) begin
      v_d[0] = bus.in_valid & !flush;
      d_d[0] = bus.in_valid ? bus.in_data : d_q[0];
    end
    v_d = flush ? '0 : v_d;
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) count_d = count_d + CW'(v_d[i]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      d_q     <= d_d;
    end
  end
  assign bus.in_ready  = go[0] & !flush;
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = d_q[DEPTH-1];
  assign count         = count_q;
endmodule
